axi_lite_config_master: RTL
===========================

AXI_LITE_CONFIG_MASTER -- requirements
Module: axi_lite_config_master
Interface
REQ-001 SHALL have parameter REG_FILE_SIZE, default 8, number of 32-bit config registers written per sequence.
REQ-002 SHALL have parameter AXI_LITE_ADDR_WIDTH, default 8, AXI-Lite address width.
REQ-003 SHALL have parameter VERIFY, default 1, readback-and-compare of every register after writes (0 = skip).
REQ-004 SHALL have m_axi_lite_aclk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have axi_resetn  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have start  in  1  one-cycle request to begin a sequence.
REQ-007 SHALL have cfg_data  in  32*REG_FILE_SIZE  flattened config words; word i in bits [32*i+:32].
REQ-008 SHALL have busy  out  1  sequence in progress.
REQ-009 SHALL have done  out  1  one-cycle pulse at sequence end.
REQ-010 SHALL have error  out  1  sticky failure flag for last sequence.
REQ-011 SHALL have err_index  out  $clog2(REG_FILE_SIZE)  index of first failing register.
REQ-012 SHALL have m_axi_lite_awaddr  out  AXI_LITE_ADDR_WIDTH  write address.
REQ-013 SHALL have m_axi_lite_awvalid  out  1  write address valid.
REQ-014 SHALL have m_axi_lite_awready  in  1  write address ready.
REQ-015 SHALL have m_axi_lite_wdata  out  32  write data.
REQ-016 SHALL have m_axi_lite_wstrb  out  4  byte strobes, constant 4'hF.
REQ-017 SHALL have m_axi_lite_wvalid  out  1  write data valid.
REQ-018 SHALL have m_axi_lite_wready  in  1  write data ready.
REQ-019 SHALL have m_axi_lite_bresp  in  2  write response.
REQ-020 SHALL have m_axi_lite_bvalid  in  1  write response valid.
REQ-021 SHALL have m_axi_lite_bready  out  1  write response ready.
REQ-022 SHALL have m_axi_lite_araddr  out  AXI_LITE_ADDR_WIDTH  read address.
REQ-023 SHALL have m_axi_lite_arvalid  out  1  read address valid.
REQ-024 SHALL have m_axi_lite_arready  in  1  read address ready.
REQ-025 SHALL have m_axi_lite_rdata  in  32  read data.
REQ-026 SHALL have m_axi_lite_rresp  in  2  read response.
REQ-027 SHALL have m_axi_lite_rvalid  in  1  read data valid.
REQ-028 SHALL have m_axi_lite_rready  out  1  read data ready.
Function
REQ-029 SHALL implement states IDLE, WADDR_DATA, WRESP, RADDR, RDATA, FINISH; index counter idx selects register.
REQ-030 SHALL, in IDLE on start=1, snapshot cfg_data, clear error and err_index, set idx=0, enter WADDR_DATA next cycle; busy=1 from that cycle until FINISH exits.
REQ-031 SHALL ignore start whenever state is not IDLE.
REQ-032 SHALL, on entering WADDR_DATA, assert awvalid and wvalid together with awaddr=idx*4 and wdata=snapshot word idx.
REQ-033 SHALL drop awvalid the cycle after awvalid&awready and wvalid the cycle after wvalid&wready, independently; neither deasserts before its handshake; address/data stable while valid.
REQ-034 SHALL enter WRESP once both handshakes are complete (same or different cycles); bready=1 only in WRESP.
REQ-035 SHALL, on bvalid in WRESP, treat bresp!=2'b00 as failure; then idx==REG_FILE_SIZE-1 goes to RADDR (idx=0) if VERIFY else FINISH; otherwise idx+1 and WADDR_DATA.
REQ-036 SHALL, in RADDR, hold arvalid=1 with araddr=idx*4 until arready, then enter RDATA; rready=1 only in RDATA.
REQ-037 SHALL, on rvalid in RDATA, treat rresp!=2'b00 or rdata!=snapshot word idx as failure; last idx goes to FINISH, else idx+1 and RADDR.
REQ-038 SHALL, on first failure only, set error=1 and latch err_index=idx; the sequence continues to completion.
REQ-039 SHALL, in FINISH, pulse done=1 for exactly one cycle, drop busy, return to IDLE; error and err_index hold until next accepted start.
REQ-040 SHALL keep at most one write and one read outstanding, never overlapping write and read phases.
Reset
REQ-041 SHALL, while axi_resetn=0, immediately force state IDLE, idx=0, all valid/ready outputs 0, busy=0, done=0, error=0, err_index=0, addresses/wdata 0.
REQ-042 SHALL, on reset assertion mid-transaction, abandon it without completing handshakes; first start after release begins a fresh sequence.
Verification
REQ-043 SHALL pass: start, cfg_data words 0x11*i, always-ready OKAY slave, VERIFY=1 -> 8 writes to addrs 0x00..0x1C then 8 reads, done once, error=0.
REQ-044 SHALL pass: slave asserts wready 3 cycles before awready on register 2 -> wvalid drops after its handshake, awvalid held, single write of word 2 to 0x08.
REQ-045 SHALL pass: slave returns bresp=2'b10 for registers 3 and 5 -> error=1, err_index=3, all 8 writes and reads still issued.
REQ-046 SHALL pass: rdata of register 6 corrupted by XOR 0x1 -> error=1, err_index=6, done pulses.
REQ-047 SHALL pass: axi_resetn low during WRESP of register 4, start pulsed while busy earlier -> outputs zero asynchronously, extra start ignored, new start restarts at address 0x00.

Source files
------------

// File: rtl/axi_lite_config_master.sv
// -----------------------------------------------------------------------------
// axi_lite_config_master
//
// Writes a block of REG_FILE_SIZE 32-bit configuration words to consecutive
// AXI-Lite registers (byte address idx*4). When VERIFY is non-zero, it then
// reads every register back and compares it with the word that was written.
// Any non-OKAY response or readback difference marks the sequence as failed.
// The index of the first failing register is kept. The sequence always runs
// to completion.
//
// Ports
//   m_axi_lite_aclk      : sole clock, rising edge
//   axi_resetn           : asynchronous active-low reset
//   start                : one-cycle request; accepted only when idle
//   cfg_data             : flattened config words, word i at [32*i +: 32]
//   busy                 : sequence in progress (through the FINISH cycle)
//   done                 : one-cycle pulse at sequence end
//   error / err_index    : sticky failure flag and first failing index
//   m_axi_lite_aw*/w*/b* : AXI-Lite write channels (one write outstanding)
//   m_axi_lite_ar*/r*    : AXI-Lite read channels (one read outstanding)
// -----------------------------------------------------------------------------
module axi_lite_config_master #(
   parameter  int REG_FILE_SIZE       = 8,
   parameter  int AXI_LITE_ADDR_WIDTH = 8,
   parameter  int VERIFY              = 1,
   localparam int IDX_W               = (REG_FILE_SIZE > 1) ? $clog2(REG_FILE_SIZE) : 1
) (
   input  logic                           m_axi_lite_aclk,
   input  logic                           axi_resetn,
   input  logic                           start,
   input  logic [32*REG_FILE_SIZE-1:0]    cfg_data,
   output logic                           busy,
   output logic                           done,
   output logic                           error,
   output logic [IDX_W-1:0]               err_index,
   output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_awaddr,
   output logic                           m_axi_lite_awvalid,
   input  logic                           m_axi_lite_awready,
   output logic [31:0]                    m_axi_lite_wdata,
   output logic [3:0]                     m_axi_lite_wstrb,
   output logic                           m_axi_lite_wvalid,
   input  logic                           m_axi_lite_wready,
   input  logic [1:0]                     m_axi_lite_bresp,
   input  logic                           m_axi_lite_bvalid,
   output logic                           m_axi_lite_bready,
   output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_araddr,
   output logic                           m_axi_lite_arvalid,
   input  logic                           m_axi_lite_arready,
   input  logic [31:0]                    m_axi_lite_rdata,
   input  logic [1:0]                     m_axi_lite_rresp,
   input  logic                           m_axi_lite_rvalid,
   output logic                           m_axi_lite_rready
);

   typedef enum logic [2:0] {
      IDLE,
      WADDR_DATA,
      WRESP,
      RADDR,
      RDATA,
      FINISH
   } state_t;

   state_t                           state, state_next;
   logic [IDX_W-1:0]                 idx;
   logic [32*REG_FILE_SIZE-1:0]      snapshot;
   logic                             aw_done, w_done;
   logic                             aw_hs, w_hs;
   logic                             last_idx;
   logic                             fail;
   logic [31:0]                      cur_word;
   logic [AXI_LITE_ADDR_WIDTH-1:0]   byte_addr;

   assign last_idx  = (idx == IDX_W'(REG_FILE_SIZE - 1));
   assign cur_word  = snapshot[32*idx +: 32];
   assign byte_addr = AXI_LITE_ADDR_WIDTH'({idx, 2'b00});

   // Address and data come straight from idx and the snapshot. Both reset to
   // zero, so these buses read zero while reset is held.
   assign m_axi_lite_awaddr = byte_addr;
   assign m_axi_lite_araddr = byte_addr;
   assign m_axi_lite_wdata  = cur_word;
   assign m_axi_lite_wstrb  = 4'hF;

   assign aw_hs = m_axi_lite_awvalid & m_axi_lite_awready;
   assign w_hs  = m_axi_lite_wvalid  & m_axi_lite_wready;

   assign fail = ((state == WRESP) && m_axi_lite_bvalid && (m_axi_lite_bresp != 2'b00)) ||
                 ((state == RDATA) && m_axi_lite_rvalid &&
                  ((m_axi_lite_rresp != 2'b00) || (m_axi_lite_rdata != cur_word)));

   // NOTE: state and datapath registers use non-blocking assignments so that
   // every flop samples values from before the clock edge.
   always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
      if (!axi_resetn) state <= IDLE;
      else             state <= state_next;
   end

   // NOTE: every signal this block drives gets a default first. This stops
   // latches from being inferred on paths that do not assign them.
   always_comb begin
      state_next         = state;
      busy               = 1'b1;
      done               = 1'b0;
      m_axi_lite_awvalid = 1'b0;
      m_axi_lite_wvalid  = 1'b0;
      m_axi_lite_bready  = 1'b0;
      m_axi_lite_arvalid = 1'b0;
      m_axi_lite_rready  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_next = WADDR_DATA;
         end
         WADDR_DATA: begin
            // Each channel drops its valid on its own handshake. The write
            // response phase waits until both channels have completed.
            m_axi_lite_awvalid = !aw_done;
            m_axi_lite_wvalid  = !w_done;
            if ((aw_done || (!aw_done && m_axi_lite_awready)) &&
                (w_done  || (!w_done  && m_axi_lite_wready)))
               state_next = WRESP;
         end
         WRESP: begin
            m_axi_lite_bready = 1'b1;
            if (m_axi_lite_bvalid) begin
               if (!last_idx)        state_next = WADDR_DATA;
               else if (VERIFY != 0) state_next = RADDR;
               else                  state_next = FINISH;
            end
         end
         RADDR: begin
            m_axi_lite_arvalid = 1'b1;
            if (m_axi_lite_arready) state_next = RDATA;
         end
         RDATA: begin
            m_axi_lite_rready = 1'b1;
            if (m_axi_lite_rvalid) state_next = last_idx ? FINISH : RADDR;
         end
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: the snapshot is a plain register bank, not a RAM. It is reset so
   // that wdata reads zero while reset is held.
   always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         idx       <= '0;
         snapshot  <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         error     <= 1'b0;
         err_index <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               snapshot  <= cfg_data;
               idx       <= '0;
               error     <= 1'b0;
               err_index <= '0;
            end
            WRESP: if (m_axi_lite_bvalid) idx <= last_idx ? '0 : idx + 1'b1;
            RDATA: if (m_axi_lite_rvalid && !last_idx) idx <= idx + 1'b1;
            default: ;
         endcase

         // The per-register handshake flags clear when the state leaves
         // WADDR_DATA, so the next register starts with both valids high.
         aw_done <= (state == WADDR_DATA) && (state_next == WADDR_DATA) && (aw_done || aw_hs);
         w_done  <= (state == WADDR_DATA) && (state_next == WADDR_DATA) && (w_done  || w_hs);

         if (fail && !error) begin
            error     <= 1'b1;
            err_index <= idx;
         end
      end
   end

endmodule
